// File: rtl/seg_disp_pkg.sv
// Shared seven-segment display definitions: blanking constants, hex glyph table, arbiter state.
package seg_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low {g,f,e,d,c,b,a} glyphs; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_arbiter.sv
// Round-robin sharing of a 4-digit seven-segment display with frame-aligned grants,
// minimum hold time and anti-ghosting blanking at the start of each digit slot.
module seg_scan_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SCAN_DIV    = 200,
    parameter int unsigned BLANK_CYC   = 8,
    parameter int unsigned HOLD_FRAMES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [16*N_REQ-1:0] value,
    output logic [N_REQ-1:0]    gnt,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                frame_done
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES) + 1;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [IDX_W-1:0]  rr_ptr, rr_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [1:0]        dig, dig_nxt;
    logic [15:0]       disp_val, disp_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [3:0]        an_nxt;
    logic [6:0]        seg_nxt;
    logic [6:0]        glyph;
    logic [IDX_W:0]    pick;
    logic              slot_tick;
    logic              boundary;

    // First requester at or after start, wrapping; MSB flags whether any was found.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        int unsigned    p;
        res = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            p = (32'(start) + k) % N_REQ;
            if (!res[IDX_W] && r[IDX_W'(p)]) begin
                res = {1'b1, IDX_W'(p)};
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return IDX_W'((32'(i) + 32'd1) % N_REQ);
    endfunction

    assign slot_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign boundary  = slot_tick && (dig == 2'd3);

    hex_to_seg u_hex_to_seg (
        .nibble (disp_val[{dig, 2'b00} +: 4]),
        .seg_c  (glyph)
    );

    // Arbitration and display capture; only the frame boundary can change ownership.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_cnt;
        disp_nxt  = disp_val;
        pick      = '0;

        if (boundary) begin
            case (state)
                ST_IDLE: begin
                    pick = rr_pick(req, rr_ptr);
                    if (pick[IDX_W]) begin
                        state_nxt = ST_OWN;
                        owner_nxt = pick[IDX_W-1:0];
                        rr_nxt    = wrap_inc(pick[IDX_W-1:0]);
                        hold_nxt  = '0;
                    end
                end
                ST_OWN: begin
                    if (!req[owner]) begin
                        pick     = rr_pick(req, wrap_inc(owner));
                        hold_nxt = '0;
                        if (pick[IDX_W]) begin
                            owner_nxt = pick[IDX_W-1:0];
                            rr_nxt    = wrap_inc(pick[IDX_W-1:0]);
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else if (hold_cnt < HOLD_W'(HOLD_FRAMES - 1)) begin
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    end else begin
                        // Owner still requests, so the scan only lands on it if nobody else does.
                        pick = rr_pick(req, wrap_inc(owner));
                        if (pick[IDX_W-1:0] != owner) begin
                            owner_nxt = pick[IDX_W-1:0];
                            rr_nxt    = wrap_inc(pick[IDX_W-1:0]);
                            hold_nxt  = '0;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            if (state_nxt == ST_OWN) begin
                disp_nxt = value[{owner_nxt, 4'b0000} +: 16];
            end
        end
    end

    // Scan counters and registered pin values derived from the current slot position.
    always_comb begin
        div_nxt = slot_tick ? '0 : div_cnt + DIV_W'(1);
        dig_nxt = slot_tick ? dig + 2'd1 : dig;
        gnt_nxt = (state_nxt == ST_OWN) ? (N_REQ'(1) << owner_nxt) : '0;
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
        if (state == ST_OWN && div_cnt >= DIV_W'(BLANK_CYC)) begin
            an_nxt  = ~(4'b0001 << dig);
            seg_nxt = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            div_cnt    <= '0;
            dig        <= '0;
            disp_val   <= '0;
            gnt        <= '0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rr_ptr     <= rr_nxt;
            hold_cnt   <= hold_nxt;
            div_cnt    <= div_nxt;
            dig        <= dig_nxt;
            disp_val   <= disp_nxt;
            gnt        <= gnt_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            frame_done <= boundary;
        end
    end

endmodule
